mips_register_file: RTL and testbench
=====================================

Name: mips_register_file

Overview:
- MIPS-style general-purpose register file for the single-cycle/pipelined datapath.
- Holds 32 registers of 32 bits each.
- Provides two asynchronous (combinational) read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between the instruction decode stage and the ALU/writeback path.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register address; depth is 2**ADDR_WIDTH (32).
- BYPASS, 0, when 1 a read of the register being written in the same cycle returns WriteData combinationally; when 0 it returns the stored (old) value until the clock edge.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ReadData1  output  DATA_WIDTH  contents of register ReadReg1.
- ReadData2  output  DATA_WIDTH  contents of register ReadReg2.
- ReadReg1  input  ADDR_WIDTH  read address, port 1.
- ReadReg2  input  ADDR_WIDTH  read address, port 2.
- WriteReg  input  ADDR_WIDTH  write address.
- WriteData  input  DATA_WIDTH  write data.
- RegWrite  input  1  write enable, active high.
- Positional instantiation order: ReadData1, ReadData2, ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, clk, rst (rst appended last so existing positional instances stay valid).

Behaviour:
- Storage: 32 x DATA_WIDTH flops, no RAM macro inference required.
- Reset:
  - Synchronous, active-high.
  - On a rising clk edge with rst=1, all 32 registers are cleared to 0.
  - rst has priority over RegWrite in the same cycle; the write is dropped.
  - Outputs read 0 for every address from the edge after reset onward.
- Read (both ports):
  - Purely combinational; ReadDataN = reg[ReadRegN].
  - Zero clock latency; output changes in the same delta as an address change.
  - If ReadRegN = 0, the output is 0 regardless of stored contents.
  - If an address is X/Z, the output may be X.
  - Both ports may address the same register simultaneously; both return the same value.
- Write:
  - On a rising clk edge with rst=0 and RegWrite=1, reg[WriteReg] <= WriteData.
  - The new value is visible on read ports immediately after that edge (one-edge write latency).
  - If WriteReg = 0, the write is discarded; register 0 always stays 0.
  - RegWrite=0: no register changes, whatever WriteReg/WriteData are.
  - WriteReg/WriteData are sampled only at the edge; changes between edges have no effect.
- Read-during-write (read address = WriteReg, RegWrite=1, same cycle):
  - BYPASS=0: output shows the old value until the edge, then the new value.
  - BYPASS=1: output shows WriteData combinationally, except for address 0, which stays 0.
- No other state, no handshake, no stall.
- All outputs are defined (0) after the first reset edge.

Test Plan:
- Reset: assert rst for 1 edge, sweep ReadReg1/ReadReg2 over 0..31 -> both outputs 0 at every address.
- Basic write/read:
  - ReadReg1=0, WriteReg=1, WriteData=37, RegWrite=1 for one edge, then RegWrite=0.
  - Set ReadReg2=1 -> ReadData2=37, ReadData1=0.
  - Reg1 stays 37 across further edges.
- Register 0 protection: WriteReg=0, WriteData=32'hFFFFFFFF, RegWrite=1, clock -> ReadData1 with ReadReg1=0 stays 0.
- Write enable low: RegWrite=0, WriteReg=5, WriteData=32'hDEADBEEF, clock several edges -> ReadReg1=5 reads 0.
- Read-during-write, BYPASS=0:
  - reg3=10; set WriteReg=3, WriteData=20, RegWrite=1, ReadReg1=ReadReg2=3.
  - Before the edge both outputs = 10; after the edge both = 20.
  - With BYPASS=1, both outputs = 20 before the edge.
- Reset priority and mid-operation reset:
  - Fill regs 1..31 with their own index.
  - Assert rst together with RegWrite=1, WriteReg=7, WriteData=99 -> after the edge all registers read 0, including reg7.
  - Writes resume normally on the next edge after rst drops.

Source files
------------

// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: 32 registers, two combinational read ports,
// one synchronous write port, register 0 hardwired to zero, optional write-to-read bypass.
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 0
) (
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  clk,
    input  logic                  rst
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Entry 0 is forced to zero so a write to it can never stick.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (RegWrite) begin
            regs_d[WriteReg] = WriteData;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        ReadData1 = regs_q[ReadReg1];
        if ((BYPASS != 0) && RegWrite && (ReadReg1 == WriteReg)) begin
            ReadData1 = WriteData;
        end
        if (ReadReg1 == '0) begin
            ReadData1 = '0;
        end
    end

    always_comb begin
        ReadData2 = regs_q[ReadReg2];
        if ((BYPASS != 0) && RegWrite && (ReadReg2 == WriteReg)) begin
            ReadData2 = WriteData;
        end
        if (ReadReg2 == '0) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: one instance without and one with bypass,
// both driven identically and checked against an array-based reference model.
module tb_mips_register_file;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_write;
    logic [AW-1:0] read_reg1, read_reg2, write_reg;
    logic [DW-1:0] write_data;
    logic [DW-1:0] rd1_nb, rd2_nb, rd1_bp, rd2_bp;

    always #5 clk = ~clk;

    mips_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0)) dut_nb (
        .ReadData1(rd1_nb), .ReadData2(rd2_nb),
        .ReadReg1(read_reg1), .ReadReg2(read_reg2),
        .WriteReg(write_reg), .WriteData(write_data), .RegWrite(reg_write),
        .clk(clk), .rst(rst)
    );

    mips_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut_bp (
        .ReadData1(rd1_bp), .ReadData2(rd2_bp),
        .ReadReg1(read_reg1), .ReadReg2(read_reg2),
        .WriteReg(write_reg), .WriteData(write_data), .RegWrite(reg_write),
        .clk(clk), .rst(rst)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] e1_nb;
        logic [DW-1:0] e2_nb;
        logic [DW-1:0] e1_bp;
        logic [DW-1:0] e2_bp;
    } exp_t;

    exp_t          exp_q[$];
    event          sample_ev;
    logic [DW-1:0] model [DEPTH];
    int            total = 0;
    int            bad   = 0;

    // Reference: register 0 reads zero; bypass forwards pending write data.
    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] ra, input bit bypass);
        if (ra == 0) return '0;
        if (bypass && reg_write && ra == write_reg) return write_data;
        return model[ra];
    endfunction

    task automatic check_output(input string name);
        exp_t e;
        e.name  = name;
        e.e1_nb = ref_read(read_reg1, 1'b0);
        e.e2_nb = ref_read(read_reg2, 1'b0);
        e.e1_bp = ref_read(read_reg1, 1'b1);
        e.e2_bp = ref_read(read_reg2, 1'b1);
        exp_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic apply_stimulus(input bit r, input bit w, input logic [AW-1:0] wa,
                                  input logic [DW-1:0] wd, input logic [AW-1:0] ra1,
                                  input logic [AW-1:0] ra2, input string name);
        @(negedge clk);
        rst = r; reg_write = w; write_reg = wa; write_data = wd;
        read_reg1 = ra1; read_reg2 = ra2;
        #1;
        check_output({name, "_pre"});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (w && wa != 0) begin
            model[wa] = wd;
        end
        #1;
        check_output({name, "_post"});
    endtask

    task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare({e.name, "/rd1_nb"}, rd1_nb, e.e1_nb);
                compare({e.name, "/rd2_nb"}, rd2_nb, e.e2_nb);
                compare({e.name, "/rd1_bp"}, rd1_bp, e.e1_bp);
                compare({e.name, "/rd2_bp"}, rd2_bp, e.e2_bp);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [AW-1:0] wa, ra1, ra2;
        bit            r, w;

        rst = 1'b1; reg_write = 1'b1; write_reg = 5'd4; write_data = 32'h1234_5678;
        read_reg1 = '0; read_reg2 = '0;
        @(posedge clk);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        rst = 1'b0; reg_write = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            read_reg1 = AW'(i);
            read_reg2 = AW'(DEPTH - 1 - i);
            #1;
            check_output($sformatf("reset_sweep%0d", i));
        end

        apply_stimulus(0, 1, 5'd1, 32'd37, 5'd0, 5'd1, "write_r1");
        apply_stimulus(0, 0, 5'd1, 32'd0, 5'd0, 5'd1, "read_r1");
        apply_stimulus(0, 0, 5'd2, 32'd5, 5'd1, 5'd1, "hold_r1");

        apply_stimulus(0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "write_r0");
        apply_stimulus(0, 0, 5'd0, 32'h0, 5'd0, 5'd1, "after_r0");

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, "we_low");
        end

        apply_stimulus(0, 1, 5'd3, 32'd10, 5'd0, 5'd0, "write_r3");
        apply_stimulus(0, 1, 5'd3, 32'd20, 5'd3, 5'd3, "rdw_r3");
        apply_stimulus(0, 0, 5'd3, 32'd0, 5'd3, 5'd3, "rdw_after");

        for (int i = 1; i < DEPTH; i++) begin
            apply_stimulus(0, 1, AW'(i), DW'(i), AW'(i), AW'(i - 1), "fill");
        end
        apply_stimulus(1, 1, 5'd7, 32'd99, 5'd7, 5'd6, "rst_prio");
        for (int i = 0; i < DEPTH; i++) begin
            read_reg1 = AW'(i);
            read_reg2 = AW'(DEPTH - 1 - i);
            #1;
            check_output($sformatf("rst_sweep%0d", i));
        end
        apply_stimulus(0, 1, 5'd7, 32'd99, 5'd7, 5'd8, "resume_w7");
        apply_stimulus(0, 0, 5'd7, 32'd0, 5'd7, 5'd0, "resume_r7");

        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 24) == 0);
            w   = ($urandom_range(0, 2) != 0);
            wa  = AW'($urandom_range(0, DEPTH - 1));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            apply_stimulus(r, w, wa, DW'($urandom), ra1, ra2, "random");
        end

        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
